// File: rtl/wbc_pkg.sv
// Shared control-bus definitions for the wbvio debug-command master.
// Holds the master FSM state encoding, the response status codes and the
// WISHBONE bus widths used by the interface and the master.
package wbc_pkg;

  localparam int WBC_DW = 32;  // data width
  localparam int WBC_AW = 20;  // byte address width
  localparam int WBC_SW = 4;   // byte-select width

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUS     = 2'd1,
    ST_BACKOFF = 2'd2,
    ST_RESP    = 2'd3
  } wbc_state_e;

  typedef enum logic [1:0] {
    WBC_ST_OK      = 2'd0,
    WBC_ST_ERR     = 2'd1,
    WBC_ST_TIMEOUT = 2'd2,
    WBC_ST_RETRY   = 2'd3
  } wbc_status_e;

endpackage

// File: rtl/wbvio_master_if.sv
// Bundle of the command/response handshakes and the wbvio WISHBONE master
// port. Signal names carry the direction as seen from the master.
//   master modport : the wbvio_master itself
//   slave  modport : command source / response sink / bus slave side
interface wbvio_master_if;
  import wbc_pkg::*;

  // command handshake
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_we_i;
  logic [WBC_AW-1:0] cmd_adr_i;
  logic [WBC_DW-1:0] cmd_dat_i;
  logic [WBC_SW-1:0] cmd_sel_i;

  // response handshake
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [WBC_DW-1:0] rsp_dat_o;
  logic [1:0]        rsp_status_o;

  // WISHBONE master port
  logic              wbvio_cyc_o;
  logic              wbvio_stb_o;
  logic              wbvio_we_o;
  logic [WBC_AW-1:0] wbvio_adr_o;
  logic [WBC_DW-1:0] wbvio_dat_o;
  logic [WBC_SW-1:0] wbvio_sel_o;
  logic              wbvio_ack_i;
  logic              wbvio_err_i;
  logic              wbvio_rty_i;
  logic [WBC_DW-1:0] wbvio_dat_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_dat_o, rsp_status_o,
    input  rsp_ready_i,
    output wbvio_cyc_o, wbvio_stb_o, wbvio_we_o, wbvio_adr_o, wbvio_dat_o, wbvio_sel_o,
    input  wbvio_ack_i, wbvio_err_i, wbvio_rty_i, wbvio_dat_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_dat_o, rsp_status_o,
    output rsp_ready_i,
    input  wbvio_cyc_o, wbvio_stb_o, wbvio_we_o, wbvio_adr_o, wbvio_dat_o, wbvio_sel_o,
    output wbvio_ack_i, wbvio_err_i, wbvio_rty_i, wbvio_dat_i
  );

endinterface

// File: rtl/wbvio_master.sv
// Debug-command WISHBONE master for the wbvio port of the control-bus
// interconnect. One command in, one classic single cycle out, one response
// back. rty re-issues the cycle after a one-cycle cyc gap (lets the
// round-robin arbiter rotate); a per-attempt timeout also covers time spent
// waiting for the grant, since terminations only reach the granted master.
// Ports:
//   clk_i   : clock
//   rst_n_i : async active-low reset; drops any cycle in flight, no response
//   bus     : wbvio_master_if.master (cmd/rsp handshakes + WISHBONE port)
// Parameters:
//   TIMEOUT_CYCLES : cycles cyc may stay high per attempt (>= 2)
//   MAX_RETRY      : re-issues allowed after rty (0..15)
module wbvio_master
  import wbc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRY      = 3
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  wbvio_master_if.master bus
);

  localparam int            TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LIM  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    RTY_LIM = 4'(MAX_RETRY);

  wbc_state_e        state_q, state_d;
  logic [TW-1:0]     to_cnt_q;
  logic [3:0]        rty_cnt_q;

  // latched command, drives the bus in every state
  logic              we_q;
  logic [WBC_AW-1:0] adr_q;
  logic [WBC_DW-1:0] dat_q;
  logic [WBC_SW-1:0] sel_q;

  // response registers, frozen while in RESP
  logic [WBC_DW-1:0] rsp_dat_q;
  wbc_status_e       rsp_st_q;

  // next-state decode side outputs
  logic              rsp_load;
  logic              retry_go;
  wbc_status_e       rsp_st_d;
  logic [WBC_DW-1:0] rsp_dat_d;

  logic              cmd_hs, rsp_hs;
  logic              cyc, cmd_rdy, rsp_vld;

  assign cmd_hs = bus.cmd_valid_i & cmd_rdy;
  assign rsp_hs = rsp_vld & bus.rsp_ready_i;

  // State register, counters and latches
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      to_cnt_q  <= '0;
      rty_cnt_q <= '0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rsp_dat_q <= '0;
      rsp_st_q  <= WBC_ST_OK;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (cmd_hs) begin
            we_q      <= bus.cmd_we_i;
            adr_q     <= bus.cmd_adr_i;
            dat_q     <= bus.cmd_dat_i;
            sel_q     <= bus.cmd_sel_i;
            to_cnt_q  <= '0;
            rty_cnt_q <= '0;
          end
        end
        ST_BUS: begin
          if (rsp_load) begin
            rsp_st_q  <= rsp_st_d;
            rsp_dat_q <= rsp_dat_d;
          end else if (retry_go) begin
            rty_cnt_q <= rty_cnt_q + 4'd1;
          end else begin
            // limit is caught by the decode before this could wrap
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        ST_BACKOFF: to_cnt_q <= '0;
        default: ;
      endcase
    end
  end

  // Next-state decode; terminations are checked before the timeout so a
  // termination on the last allowed cycle still wins.
  always_comb begin
    state_d   = state_q;
    rsp_load  = 1'b0;
    retry_go  = 1'b0;
    rsp_st_d  = WBC_ST_OK;
    rsp_dat_d = '0;
    case (state_q)
      ST_IDLE: if (cmd_hs) state_d = ST_BUS;
      ST_BUS: begin
        if (bus.wbvio_err_i) begin
          state_d  = ST_RESP;
          rsp_load = 1'b1;
          rsp_st_d = WBC_ST_ERR;
        end else if (bus.wbvio_ack_i) begin
          state_d   = ST_RESP;
          rsp_load  = 1'b1;
          rsp_st_d  = WBC_ST_OK;
          rsp_dat_d = we_q ? '0 : bus.wbvio_dat_i;
        end else if (bus.wbvio_rty_i) begin
          if (rty_cnt_q < RTY_LIM) begin
            state_d  = ST_BACKOFF;
            retry_go = 1'b1;
          end else begin
            state_d  = ST_RESP;
            rsp_load = 1'b1;
            rsp_st_d = WBC_ST_RETRY;
          end
        end else if (to_cnt_q == TO_LIM) begin
          state_d  = ST_RESP;
          rsp_load = 1'b1;
          rsp_st_d = WBC_ST_TIMEOUT;
        end
      end
      ST_BACKOFF: state_d = ST_BUS;
      ST_RESP:    if (rsp_hs) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    cyc     = (state_q == ST_BUS);
    cmd_rdy = (state_q == ST_IDLE);
    rsp_vld = (state_q == ST_RESP);
  end

  assign bus.cmd_ready_o  = cmd_rdy;
  assign bus.rsp_valid_o  = rsp_vld;
  assign bus.rsp_dat_o    = rsp_dat_q;
  assign bus.rsp_status_o = rsp_st_q;
  assign bus.wbvio_cyc_o  = cyc;
  assign bus.wbvio_stb_o  = cyc;
  assign bus.wbvio_we_o   = we_q;
  assign bus.wbvio_adr_o  = adr_q;
  assign bus.wbvio_dat_o  = dat_q;
  assign bus.wbvio_sel_o  = sel_q;

endmodule

// File: tb/tb_wbvio_master.sv
// Directed bench for wbvio_master. dut uses TIMEOUT_CYCLES=16, MAX_RETRY=3;
// dut1 uses MAX_RETRY=1 for the retry-exhaustion case. Inputs change and
// outputs are sampled on the falling edge.
module tb_wbvio_master;
  import wbc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  wbvio_master_if bus ();
  wbvio_master_if bus1 ();

  wbvio_master #(.TIMEOUT_CYCLES(16), .MAX_RETRY(3)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus.master)
  );
  wbvio_master #(.TIMEOUT_CYCLES(16), .MAX_RETRY(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus1.master)
  );

  task automatic init_inputs();
    bus.cmd_valid_i = 0; bus.cmd_we_i = 0; bus.cmd_adr_i = '0; bus.cmd_dat_i = '0;
    bus.cmd_sel_i = '0; bus.rsp_ready_i = 0; bus.wbvio_ack_i = 0; bus.wbvio_err_i = 0;
    bus.wbvio_rty_i = 0; bus.wbvio_dat_i = '0;
    bus1.cmd_valid_i = 0; bus1.cmd_we_i = 0; bus1.cmd_adr_i = '0; bus1.cmd_dat_i = '0;
    bus1.cmd_sel_i = '0; bus1.rsp_ready_i = 0; bus1.wbvio_ack_i = 0; bus1.wbvio_err_i = 0;
    bus1.wbvio_rty_i = 0; bus1.wbvio_dat_i = '0;
  endtask

  // Present a command on dut at a falling edge; returns at the falling edge
  // after the accepting clock edge.
  task automatic issue(input logic we, input logic [19:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    logic ok;
    ok = 0;
    bus.cmd_we_i = we; bus.cmd_adr_i = adr; bus.cmd_dat_i = dat; bus.cmd_sel_i = sel;
    bus.cmd_valid_i = 1;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = bus.cmd_ready_o;
      @(negedge clk);
    end
    bus.cmd_valid_i = 0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL issue_handshake cmd_ready_o never seen high within 20 cycles");
    end
  endtask

  task automatic consume();
    bus.rsp_ready_i = 1;
    @(negedge clk);
    bus.rsp_ready_i = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus.wbvio_cyc_o, bus.wbvio_stb_o, bus.rsp_valid_o, bus.cmd_ready_o} !== 4'b0001) begin
      failures++;
      $display("FAIL reset_ctrl cyc/stb/rsp_valid/cmd_ready got=%b exp=0001",
               {bus.wbvio_cyc_o, bus.wbvio_stb_o, bus.rsp_valid_o, bus.cmd_ready_o});
    end
    checks++;
    if ({bus.rsp_status_o, bus.rsp_dat_o, bus.wbvio_we_o, bus.wbvio_adr_o, bus.wbvio_dat_o,
         bus.wbvio_sel_o} !== 83'h0) begin
      failures++;
      $display("FAIL reset_data status=%0d rsp_dat=%h adr=%h dat=%h sel=%h exp all 0",
               bus.rsp_status_o, bus.rsp_dat_o, bus.wbvio_adr_o, bus.wbvio_dat_o, bus.wbvio_sel_o);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_read_wait3();
    int cyc_n;
    logic got;
    issue(1'b0, 20'h10004, 32'h0, 4'hF);
    cyc_n = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (bus.rsp_valid_o) got = 1;
      else begin
        if (bus.wbvio_cyc_o) cyc_n++;
        bus.wbvio_ack_i = bus.wbvio_cyc_o && (cyc_n == 3);
        bus.wbvio_dat_i = bus.wbvio_ack_i ? 32'hDEADBEEF : 32'h0;
        @(negedge clk);
      end
    end
    bus.wbvio_ack_i = 0;
    checks++;
    if (!got || cyc_n != 3) begin
      failures++;
      $display("FAIL read_cyc_len rsp_seen=%b cyc_cycles=%0d exp 1/3", got, cyc_n);
    end
    checks++;
    if ({bus.rsp_status_o, bus.rsp_dat_o, bus.wbvio_adr_o} !== {2'd0, 32'hDEADBEEF, 20'h10004}) begin
      failures++;
      $display("FAIL read_rsp status=%0d dat=%h adr=%h exp 0/deadbeef/10004",
               bus.rsp_status_o, bus.rsp_dat_o, bus.wbvio_adr_o);
    end
    consume();
    checks++;
    if ({bus.rsp_valid_o, bus.cmd_ready_o} !== 2'b01) begin
      failures++;
      $display("FAIL read_consume rsp_valid/cmd_ready got=%b exp=01", {bus.rsp_valid_o, bus.cmd_ready_o});
    end
  endtask

  task automatic test_write_zero_wait();
    issue(1'b1, 20'h80000, 32'h12345678, 4'hF);
    checks++;
    if ({bus.wbvio_cyc_o, bus.wbvio_stb_o, bus.wbvio_we_o, bus.rsp_valid_o} !== 4'b1110) begin
      failures++;
      $display("FAIL write_ctrl cyc/stb/we/rsp_valid got=%b exp=1110",
               {bus.wbvio_cyc_o, bus.wbvio_stb_o, bus.wbvio_we_o, bus.rsp_valid_o});
    end
    checks++;
    if ({bus.wbvio_adr_o, bus.wbvio_dat_o, bus.wbvio_sel_o} !== {20'h80000, 32'h12345678, 4'hF}) begin
      failures++;
      $display("FAIL write_bus adr=%h dat=%h sel=%h exp 80000/12345678/f",
               bus.wbvio_adr_o, bus.wbvio_dat_o, bus.wbvio_sel_o);
    end
    bus.wbvio_ack_i = 1; bus.wbvio_dat_i = 32'hFFFFFFFF;
    @(negedge clk);
    bus.wbvio_ack_i = 0; bus.wbvio_dat_i = '0;
    checks++;
    if ({bus.rsp_valid_o, bus.wbvio_cyc_o, bus.rsp_status_o, bus.rsp_dat_o} !== {2'b10, 2'd0, 32'h0}) begin
      failures++;
      $display("FAIL write_rsp rsp_valid=%b cyc=%b status=%0d dat=%h exp 1/0/0/0",
               bus.rsp_valid_o, bus.wbvio_cyc_o, bus.rsp_status_o, bus.rsp_dat_o);
    end
    consume();
  endtask

  task automatic test_retry_then_ack();
    int att, gaps;
    logic got;
    issue(1'b0, 20'h00040, 32'h0, 4'h3);
    att = 0; gaps = 0; got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (bus.rsp_valid_o) got = 1;
      else begin
        if (bus.wbvio_cyc_o) begin
          att++;
          bus.wbvio_rty_i = (att <= 2);
          bus.wbvio_ack_i = (att == 3);
          bus.wbvio_dat_i = 32'h0BADF00D;
        end else begin
          gaps++;
          bus.wbvio_rty_i = 0; bus.wbvio_ack_i = 0;
        end
        @(negedge clk);
      end
    end
    bus.wbvio_rty_i = 0; bus.wbvio_ack_i = 0;
    checks++;
    if (!got || att != 3 || gaps != 2) begin
      failures++;
      $display("FAIL retry_shape rsp_seen=%b attempts=%0d gaps=%0d exp 1/3/2", got, att, gaps);
    end
    checks++;
    if ({bus.rsp_status_o, bus.rsp_dat_o} !== {2'd0, 32'h0BADF00D}) begin
      failures++;
      $display("FAIL retry_rsp status=%0d dat=%h exp 0/0badf00d", bus.rsp_status_o, bus.rsp_dat_o);
    end
    consume();
  endtask

  task automatic test_retry_exhaust();
    int att, gaps;
    logic got;
    checks++;
    if (bus1.cmd_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL exhaust_ready cmd_ready got=%b exp=1", bus1.cmd_ready_o);
    end
    bus1.cmd_we_i = 0; bus1.cmd_adr_i = 20'h00100; bus1.cmd_sel_i = 4'hF; bus1.cmd_valid_i = 1;
    @(negedge clk);
    bus1.cmd_valid_i = 0;
    att = 0; gaps = 0; got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (bus1.rsp_valid_o) got = 1;
      else begin
        if (bus1.wbvio_cyc_o) att++;
        else gaps++;
        bus1.wbvio_rty_i = bus1.wbvio_cyc_o;
        bus1.wbvio_dat_i = 32'h55555555;
        @(negedge clk);
      end
    end
    bus1.wbvio_rty_i = 0;
    checks++;
    if (!got || att != 2 || gaps != 1) begin
      failures++;
      $display("FAIL exhaust_shape rsp_seen=%b attempts=%0d gaps=%0d exp 1/2/1", got, att, gaps);
    end
    checks++;
    if ({bus1.rsp_status_o, bus1.rsp_dat_o} !== {2'd3, 32'h0}) begin
      failures++;
      $display("FAIL exhaust_rsp status=%0d dat=%h exp 3/0", bus1.rsp_status_o, bus1.rsp_dat_o);
    end
    bus1.rsp_ready_i = 1;
    @(negedge clk);
    bus1.rsp_ready_i = 0;
  endtask

  task automatic test_timeout(input logic ack_last);
    int cyc_n;
    logic got;
    issue(1'b0, 20'h0FFFC, 32'h0, 4'hF);
    cyc_n = 0; got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (bus.rsp_valid_o) got = 1;
      else begin
        if (bus.wbvio_cyc_o) cyc_n++;
        bus.wbvio_ack_i = ack_last && bus.wbvio_cyc_o && (cyc_n == 16);
        bus.wbvio_dat_i = 32'hCAFE0001;
        @(negedge clk);
      end
    end
    bus.wbvio_ack_i = 0;
    checks++;
    if (!got || cyc_n != 16) begin
      failures++;
      $display("FAIL timeout_len ack_last=%b rsp_seen=%b cyc_cycles=%0d exp 1/16", ack_last, got, cyc_n);
    end
    checks++;
    if (ack_last ? ({bus.rsp_status_o, bus.rsp_dat_o} !== {2'd0, 32'hCAFE0001})
                 : ({bus.rsp_status_o, bus.rsp_dat_o} !== {2'd2, 32'h0})) begin
      failures++;
      $display("FAIL timeout_rsp ack_last=%b status=%0d dat=%h exp %s", ack_last,
               bus.rsp_status_o, bus.rsp_dat_o, ack_last ? "0/cafe0001" : "2/0");
    end
    consume();
  endtask

  task automatic test_err_and_ack();
    issue(1'b0, 20'h00008, 32'h0, 4'hF);
    bus.wbvio_err_i = 1; bus.wbvio_ack_i = 1; bus.wbvio_dat_i = 32'hFFFF0000;
    @(negedge clk);
    bus.wbvio_err_i = 0; bus.wbvio_ack_i = 0;
    checks++;
    if ({bus.rsp_valid_o, bus.rsp_status_o, bus.rsp_dat_o} !== {1'b1, 2'd1, 32'h0}) begin
      failures++;
      $display("FAIL err_ack rsp_valid=%b status=%0d dat=%h exp 1/1/0",
               bus.rsp_valid_o, bus.rsp_status_o, bus.rsp_dat_o);
    end
    consume();
  endtask

  task automatic test_rsp_hold();
    int bad;
    issue(1'b0, 20'h00020, 32'h0, 4'hF);
    bus.wbvio_ack_i = 1; bus.wbvio_dat_i = 32'hA5A55A5A;
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      // stray terminations while waiting must not disturb the response
      bus.wbvio_ack_i = 1; bus.wbvio_err_i = (i == 2); bus.wbvio_dat_i = 32'h11111111 * i;
      checks++;
      if ({bus.rsp_valid_o, bus.cmd_ready_o, bus.wbvio_cyc_o, bus.rsp_status_o, bus.rsp_dat_o}
          !== {3'b100, 2'd0, 32'hA5A55A5A}) begin
        failures++;
        $display("FAIL rsp_hold cycle=%0d rsp_valid=%b cmd_ready=%b cyc=%b status=%0d dat=%h exp 1/0/0/0/a5a55a5a",
                 i, bus.rsp_valid_o, bus.cmd_ready_o, bus.wbvio_cyc_o, bus.rsp_status_o, bus.rsp_dat_o);
      end
      @(negedge clk);
    end
    bus.wbvio_ack_i = 0; bus.wbvio_err_i = 0;
    consume();
  endtask

  task automatic test_reset_mid_bus();
    issue(1'b1, 20'h00444, 32'h99999999, 4'h1);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    checks++;
    if ({bus.wbvio_cyc_o, bus.wbvio_stb_o, bus.rsp_valid_o, bus.cmd_ready_o} !== 4'b0001) begin
      failures++;
      $display("FAIL mid_reset cyc/stb/rsp_valid/cmd_ready got=%b exp=0001",
               {bus.wbvio_cyc_o, bus.wbvio_stb_o, bus.rsp_valid_o, bus.cmd_ready_o});
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    issue(1'b0, 20'h00ABC, 32'h0, 4'hF);
    bus.wbvio_ack_i = 1; bus.wbvio_dat_i = 32'h13572468;
    @(negedge clk);
    bus.wbvio_ack_i = 0;
    checks++;
    if ({bus.rsp_valid_o, bus.rsp_status_o, bus.rsp_dat_o} !== {1'b1, 2'd0, 32'h13572468}) begin
      failures++;
      $display("FAIL post_reset_cmd rsp_valid=%b status=%0d dat=%h exp 1/0/13572468",
               bus.rsp_valid_o, bus.rsp_status_o, bus.rsp_dat_o);
    end
    consume();
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_read_wait3();
    test_write_zero_wait();
    test_retry_then_ack();
    test_retry_exhaust();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_err_and_ack();
    test_rsp_hold();
    test_reset_mid_bus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wbvio_master.md
# wbvio_master

Debug-command WISHBONE master that drives the `wbvio` master port of the control-bus interconnect. It accepts single read or write commands over a valid/ready handshake and runs one classic WISHBONE cycle per command. It retries on `rty`, aborts on a bus timeout, and returns read data plus a status code over a second valid/ready handshake. The timeout also covers arbitration stalls: the interconnect only passes `ack`/`err`/`rty` to a master that holds the grant.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1024: maximum cycles `cyc_o` may stay high per attempt before abort; minimum 2.
- `MAX_RETRY`, 3: number of re-issues allowed after `rty_i`; range 0–15.

Ports:
- `clk_i` in 1: sole clock.
- `rst_n_i` in 1: reset, asynchronous assert, active-low.
- `cmd_valid_i` in 1: command present.
- `cmd_ready_o` out 1: command accepted when both valid and ready are high.
- `cmd_we_i` in 1: 1 = write.
- `cmd_adr_i` in 20: byte address.
- `cmd_dat_i` in 32: write data.
- `cmd_sel_i` in 4: byte selects.
- `rsp_valid_o` out 1: response present.
- `rsp_ready_i` in 1: response consumed when both valid and ready are high.
- `rsp_dat_o` out 32: read data; 0 for writes and failed cycles.
- `rsp_status_o` out 2: 0 = OK, 1 = ERR, 2 = TIMEOUT, 3 = RETRY_EXHAUSTED.
- `wbvio_cyc_o`, `wbvio_stb_o`, `wbvio_we_o` out 1 each: WISHBONE master controls.
- `wbvio_adr_o` out 20, `wbvio_dat_o` out 32, `wbvio_sel_o` out 4: WISHBONE master address, data, selects.
- `wbvio_ack_i`, `wbvio_err_i`, `wbvio_rty_i` in 1 each: cycle terminations.
- `wbvio_dat_i` in 32: read data.

## Operation
- States:
  - IDLE: `cmd_ready_o`=1.
  - BUS: `cyc`=`stb`=1.
  - BACKOFF: `cyc`=0 for one cycle, so the round-robin arbiter can rotate.
  - RESP: `rsp_valid_o`=1.
- IDLE→BUS on handshake. The command fields are latched into registers that drive `wbvio_we/adr/dat/sel_o`. Retry count and timeout count clear.
- In BUS, each cycle is resolved by the first matching rule:
  1. `err_i` → RESP with ERR.
  2. `ack_i` → RESP with OK; `rsp_dat_o` latches `dat_i` for reads and is 0 for writes.
  3. `rty_i` with retry count < MAX_RETRY → BACKOFF and increment the count.
  4. `rty_i` with the count exhausted → RESP with RETRY_EXHAUSTED.
  5. Timeout count == TIMEOUT_CYCLES−1 → RESP with TIMEOUT.
  6. Otherwise increment the timeout count.
- A termination and the timeout limit in the same cycle: the termination wins.
- BACKOFF→BUS unconditionally; the timeout count clears and the latched command is unchanged.
- RESP→IDLE on the response handshake. The response fields stay stable while `rsp_valid_o` is high.
- Terminations received outside BUS are ignored.
- Address, data and sel are driven from the latched registers in all states; their values outside BUS are don't-care.
- Timeout counter is `$clog2(TIMEOUT_CYCLES)` bits and never wraps. Retry counter is 4 bits.

## Timing
- Reset (asynchronous, immediate): state IDLE. All outputs 0 except `cmd_ready_o`=1. A cycle in progress is dropped with no response; `cyc_o` falls asynchronously.
- Command handshake at edge N → `cyc_o`/`stb_o` high from N+1.
- Termination sampled at edge M → `cyc_o`=0 and `rsp_valid_o`=1 from M+1. Minimum command-to-response latency is 2 cycles with a zero-wait slave.
- A new command can be accepted, at the earliest, the cycle after the response handshake. Throughput is at most 1 command per 3 cycles.
- Each retry costs one BACKOFF cycle plus the new attempt.
- Timeout: with no termination, `cyc_o` is high for exactly TIMEOUT_CYCLES cycles, then `rsp_valid_o` rises.
- `stb_o` always equals `cyc_o`. Single classic cycles only; no bursts, no pipelined mode.

## Structure
- Shared `wbc_pkg`:
  - the state enum;
  - the status codes `WBC_ST_OK/ERR/TIMEOUT/RETRY`;
  - bus widths of 32 data, 20 address, 4 sel.
- Single flat module; no sub-module.
- One `always_ff` block for state, counters and latches; combinational output decode.

## Test plan
- Read 0x10004; slave acks at the 3rd `cyc` cycle with 0xDEADBEEF → `rsp_dat_o`=0xDEADBEEF, status 0; `cyc_o` high exactly 3 cycles.
- Write 0x80000, data 0x12345678, sel 0xF; zero-wait ack → bus shows the exact adr/dat/sel/we; `rsp_valid_o` at handshake+2; `rsp_dat_o`=0, status 0.
- Slave asserts `rty` twice, then acks → two 1-cycle `cyc_o` gaps, status 0. With MAX_RETRY=1 → status 3 after the second `rty`.
- No termination, TIMEOUT_CYCLES=16 → `cyc_o` high exactly 16 cycles, status 2. `ack` arriving on the 16th cycle instead → status 0.
- `err` and `ack` asserted together → status 1. `rsp_ready_i` held low for 5 cycles → response stable, `cmd_ready_o`=0 throughout.
- `rst_n_i` pulsed low mid-BUS → `cyc_o` and `rsp_valid_o` fall immediately, `cmd_ready_o`=1; the next command completes normally.
